uart_tx_fifo: RTL

- Transmit buffer between the AXI-lite UART controller (upstream) and the UART serializer (downstream).
- Accepts bytes from the controller on a valid/ready stream and stores them in a power-of-two circular buffer.
- Presents bytes first-word-fall-through to the serializer.
- Exports full, empty, occupancy, almost-full and sticky overflow/underflow status for the controller's status register.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 33 +++
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART package.
// Holds the character width, the default transmit-buffer depth and the
// FIFO status bundle that the controller packs into its status word.
package uart_pkg;

  localparam int UART_DLEN = 8;
  localparam int TXB_DEPTH = 16;

  // Status bundle for the controller's status word.
  // The field order is fixed because the controller packs it into a register.
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic empty;
    logic afull;
    logic full;
  } uart_fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. The contents are not reset. The tx buffer uses it,
// and the rx buffer will reuse it.
// Ports:
//   clk            write clock
//   we             write enable
//   waddr / wdata  write index and write data
//   raddr          read index
//   rdata          combinational read data, mem[raddr]
module uart_fifo_mem #(
  parameter int DLEN  = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DLEN-1:0] rdata
);

  logic [DLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer.
// Sits between the AXI-lite UART controller and the serializer. It is a
// power-of-two circular buffer with first-word fall-through output.
// Ports:
//   clk, rstn                    clock and synchronous active-low reset
//   i_clr                        synchronous flush of contents and sticky flags
//   i_s_tvalid/o_s_tready/i_s_tdata  upstream byte stream from the controller
//   o_m_tvalid/i_m_tready/o_m_tdata  downstream byte stream to the serializer
//   o_full, o_empty, o_afull     occupancy flags
//   o_count                      occupancy, 0..DEPTH
//   o_overflow, o_underflow      sticky error flags
//
// Handshake: a byte moves on a stream only in a cycle where valid and ready
// are both 1. The source holds data stable while valid is 1 and ready is 0.
// Both ready and valid are decoded from registered pointers only, so neither
// of them depends combinationally on the opposite port.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DLEN      = UART_DLEN,
  parameter int DEPTH     = TXB_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_clr,
  input  logic            i_s_tvalid,
  output logic            o_s_tready,
  input  logic [DLEN-1:0] i_s_tdata,
  output logic            o_m_tvalid,
  input  logic            i_m_tready,
  output logic [DLEN-1:0] o_m_tdata,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_afull,
  output logic [AW:0]     o_count,
  output logic            o_overflow,
  output logic            o_underflow
);

  localparam logic [AW:0] AFULL_THR = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  // Each pointer has one extra wrap bit above the index bits.
  logic [AW:0] wptr, rptr, count;
  logic        ovf_q, udf_q;
  logic        full, empty;
  logic        push, pop;
  logic        mem_we;

  uart_fifo_status_t status;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign push = i_s_tvalid & ~full;
  assign pop  = i_m_tready & ~empty;

  // A byte offered during a flush or reset cycle is discarded.
  // The write is gated here so that no stale write lands in the array.
  assign mem_we = push & rstn & ~i_clr;

  always_ff @(posedge clk) begin
    if (!rstn || i_clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
      if (i_s_tvalid && full)  ovf_q <= 1'b1;
      if (i_m_tready && empty) udf_q <= 1'b1;
    end
  end

  uart_fifo_mem #(
    .DLEN  (DLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr[AW-1:0]),
    .wdata (i_s_tdata),
    .raddr (rptr[AW-1:0]),
    .rdata (o_m_tdata)
  );

  always_comb begin
    status           = '0;
    status.overflow  = ovf_q;
    status.underflow = udf_q;
    status.empty     = empty;
    status.afull     = (count >= AFULL_THR);
    status.full      = full;
  end

  assign o_full      = status.full;
  assign o_empty     = status.empty;
  assign o_afull     = status.afull;
  assign o_overflow  = status.overflow;
  assign o_underflow = status.underflow;
  assign o_count     = count;
  assign o_s_tready  = ~status.full;
  assign o_m_tvalid  = ~status.empty;

endmodule
